collision_scan_ctrl: RTL

- Per-frame scheduler that time-multiplexes the single tile-vs-character collision checker across every ground tile in the level tile ROM.
- On each frame_start it latches the character position, walks tile addresses 0..NUM_TILES-1 and feeds the checker. It OR-accumulates the checker's 4-bit side flags and publishes one consolidated result per frame to the movement/physics logic.

---
 rtl/collision_pkg.sv | 19 +
 rtl/coll_valid_pipe.sv | 30 +++
 rtl/collision_scan_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/collision_pkg.sv
// Shared types and constants for the collision scan controller and its pipeline.
package collision_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int COLL_DOWN  = 0;
    localparam int COLL_UP    = 1;
    localparam int COLL_RIGHT = 2;
    localparam int COLL_LEFT  = 3;

    localparam int X_W = 10;
    localparam int Y_W = 9;

endpackage

// File: rtl/coll_valid_pipe.sv
// DEPTH-stage shift register that carries per-tile sideband (valid, enable, address tag)
// alongside the ROM read and checker latency.
module coll_valid_pipe #(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/collision_scan_ctrl.sv
// Per-frame scheduler that walks the tile ROM through the single collision checker and
// OR-accumulates its side flags. Define COLL_LAND_IDX_EN to also report the landing tile index.
module collision_scan_ctrl
    import collision_pkg::*;
#(
    parameter int NUM_TILES = 64,
    parameter int IDX_W     = 6,
    parameter int PIPE_LAT  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [X_W-1:0]   x_blue_in,
    input  logic [Y_W-1:0]   y_blue_in,
    output logic [IDX_W-1:0] tile_addr,
    input  logic [X_W-1:0]   tile_x,
    input  logic [Y_W-1:0]   tile_y,
    input  logic             tile_en,
    output logic [X_W-1:0]   x_blue,
    output logic [Y_W-1:0]   y_blue,
    output logic [X_W-1:0]   x_ground,
    output logic [Y_W-1:0]   y_ground,
    input  logic [3:0]       is_Collision,
    output logic [3:0]       coll_flags,
    output logic             done,
    output logic             busy
`ifdef COLL_LAND_IDX_EN
    ,
    output logic [IDX_W-1:0] land_idx,
    output logic             land_valid
`endif
);

    localparam int CNT_W = IDX_W + 1;
    localparam int DRN_W = $clog2(PIPE_LAT + 1);
`ifdef COLL_LAND_IDX_EN
    localparam int PIPE_W = 1 + IDX_W;
`else
    localparam int PIPE_W = 1;
`endif

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DRN_W-1:0]   drn_q;
    logic [X_W-1:0]     xb_q;
    logic [Y_W-1:0]     yb_q;
    logic [3:0]         acc_q;
    logic [3:0]         acc_d;
    logic [3:0]         flags_q;
    logic               done_q;
    logic               busy_q;
    logic [PIPE_W-1:0]  pipe_d;
    logic [PIPE_W-1:0]  pipe_q;
    logic               en_q;
    logic               hit;

    // Valid (and address tag) enter at issue; tile_en joins one stage later with the ROM data.
`ifdef COLL_LAND_IDX_EN
    logic [IDX_W-1:0]   land_acc_q;
    logic [IDX_W-1:0]   land_acc_d;
    logic [IDX_W-1:0]   land_idx_q;
    logic               land_valid_q;

    assign pipe_d = {state_q == SCAN, tile_addr};
`else
    assign pipe_d = (state_q == SCAN);
`endif

    coll_valid_pipe #(.DEPTH(PIPE_LAT), .W(PIPE_W)) u_vld_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pipe_d),
        .q_o   (pipe_q)
    );

    coll_valid_pipe #(.DEPTH(PIPE_LAT - 1), .W(1)) u_en_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (tile_en),
        .q_o   (en_q)
    );

    assign hit   = pipe_q[PIPE_W-1] & en_q;
    assign acc_d = hit ? (acc_q | is_Collision) : acc_q;

`ifdef COLL_LAND_IDX_EN
    // Tiles arrive in ascending address order, so the first down hit is the lowest index.
    assign land_acc_d = (hit && is_Collision[COLL_DOWN] && !acc_q[COLL_DOWN])
                        ? pipe_q[IDX_W-1:0] : land_acc_q;
    assign land_idx   = land_idx_q;
    assign land_valid = land_valid_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            drn_q        <= '0;
            xb_q         <= '0;
            yb_q         <= '0;
            acc_q        <= '0;
            flags_q      <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
`ifdef COLL_LAND_IDX_EN
            land_acc_q   <= '0;
            land_idx_q   <= '0;
            land_valid_q <= 1'b0;
`endif
        end else begin
            acc_q  <= acc_d;
            done_q <= 1'b0;
`ifdef COLL_LAND_IDX_EN
            land_acc_q <= land_acc_d;
`endif
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        xb_q    <= x_blue_in;
                        yb_q    <= y_blue_in;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
`ifdef COLL_LAND_IDX_EN
                        land_acc_q <= '0;
`endif
                    end
                end
                SCAN: begin
                    if (cnt_q == CNT_W'(NUM_TILES - 1)) begin
                        drn_q   <= '0;
                        state_q <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    // Publish on the edge that folds in the last tile so done and the flags coincide.
                    if (drn_q == DRN_W'(PIPE_LAT - 1)) begin
                        flags_q <= acc_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
`ifdef COLL_LAND_IDX_EN
                        land_idx_q   <= land_acc_d;
                        land_valid_q <= acc_d[COLL_DOWN];
`endif
                    end else begin
                        drn_q <= drn_q + DRN_W'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tile_addr  = cnt_q[IDX_W-1:0];
    assign x_blue     = xb_q;
    assign y_blue     = yb_q;
    assign x_ground   = tile_x;
    assign y_ground   = tile_y;
    assign coll_flags = flags_q;
    assign done       = done_q;
    assign busy       = busy_q;

endmodule
